// File: rtl/output_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | output_serializer: buffers 40-bit L/R result pairs and shifts them out    |
// | MSB-first per Sclk. Optional macro: OUTPUT_SERIALIZER_WORDCNT_EN          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module output_serializer #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 2
) (
   input  logic             Sclk,
   input  logic             Reset_n_sig,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataL,
   input  logic [WIDTH-1:0] dataR,
   output logic             OutReady_sig,
   output logic             OutputL_sig,
   output logic             OutputR_sig,
   output logic [15:0]      words_sent
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_l_q [DEPTH];
   logic [WIDTH-1:0] mem_l_d [DEPTH];
   logic [WIDTH-1:0] mem_r_q [DEPTH];
   logic [WIDTH-1:0] mem_r_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] sh_l_q, sh_l_d;
   logic [WIDTH-1:0] sh_r_q, sh_r_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             out_rdy_q, out_rdy_d;
   logic             in_ready_q, in_ready_d;
   logic             push;
   logic             load;

   always_comb begin
      state_d   = state_q;
      mem_l_d   = mem_l_q;
      mem_r_d   = mem_r_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      sh_l_d    = sh_l_q;
      sh_r_d    = sh_r_q;
      bit_cnt_d = bit_cnt_q;
      out_rdy_d = out_rdy_q;
      push      = 1'b0;
      load      = 1'b0;

      if (flush) begin
         state_d   = IDLE;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         sh_l_d    = '0;
         sh_r_d    = '0;
         bit_cnt_d = '0;
         out_rdy_d = 1'b0;
      end else begin
         push = in_valid && in_ready_q;

         // The pop decision uses the registered count, so a word pushed this
         // edge cannot be loaded until the next one.
         case (state_q)
            IDLE: begin
               load = (count_q != '0);
            end
            SHIFT: begin
               if (bit_cnt_q != '0) begin
                  sh_l_d    = {sh_l_q[WIDTH-2:0], 1'b0};
                  sh_r_d    = {sh_r_q[WIDTH-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - BW'(1);
               end else begin
                  load = (count_q != '0);
                  if (!load) begin
                     state_d   = IDLE;
                     sh_l_d    = '0;
                     sh_r_d    = '0;
                     out_rdy_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (load) begin
            sh_l_d    = mem_l_q[rd_ptr_q];
            sh_r_d    = mem_r_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PW'(1);
            bit_cnt_d = LAST_BIT;
            out_rdy_d = 1'b1;
            state_d   = SHIFT;
         end

         if (push) begin
            mem_l_d[wr_ptr_q] = dataL;
            mem_r_d[wr_ptr_q] = dataR;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end

         case ({push, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      in_ready_d = (count_d != FULL_COUNT);
   end

   always_ff @(posedge Sclk or negedge Reset_n_sig) begin
      if (!Reset_n_sig) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sh_l_q     <= '0;
         sh_r_q     <= '0;
         bit_cnt_q  <= '0;
         out_rdy_q  <= 1'b0;
         in_ready_q <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            mem_l_q[i] <= '0;
            mem_r_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sh_l_q     <= sh_l_d;
         sh_r_q     <= sh_r_d;
         bit_cnt_q  <= bit_cnt_d;
         out_rdy_q  <= out_rdy_d;
         in_ready_q <= in_ready_d;
         mem_l_q    <= mem_l_d;
         mem_r_q    <= mem_r_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign OutReady_sig = out_rdy_q;
   assign OutputL_sig  = sh_l_q[WIDTH-1];
   assign OutputR_sig  = sh_r_q[WIDTH-1];

`ifdef OUTPUT_SERIALIZER_WORDCNT_EN
   logic [15:0] words_q, words_d;
   logic        word_done;

   // A word is complete on the edge after bit 0 was presented; flush aborts it.
   always_comb begin
      word_done = !flush && (state_q == SHIFT) && (bit_cnt_q == '0);
      words_d   = words_q;
      if (word_done) begin
         words_d = words_q + 16'd1;
      end
   end

   always_ff @(posedge Sclk or negedge Reset_n_sig) begin
      if (!Reset_n_sig) begin
         words_q <= 16'd0;
      end else begin
         words_q <= words_d;
      end
   end

   assign words_sent = words_q;
`else
   assign words_sent = 16'd0;
`endif

endmodule
`default_nettype wire
